// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding controller for the in-order MIPS pipeline.
// A shift-register scoreboard tracks {valid, dst, rdy} for every instruction
// downstream of decode. Pos1 is E, pos2 is M, and pos DEPTH is W.
// Each source's hit position is captured at D and carried down a small pipe.
// Later stages can then pick the right result bus.
// Layout of fwd_sel: source s, stage j occupies bits [(s*DEPTH + j)*SELW +: SELW].
// DEPTH must be at least 2.
module hazard_fwd_unit #(
    parameter int NSRC    = 3,
    parameter int DEPTH   = 3,
    parameter int REGW    = 5,
    parameter int MDU_LAT = 5,
    parameter int UW      = $clog2(DEPTH),
    parameter int SELW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         d_valid,
    input  logic [NSRC*REGW-1:0]         d_src,
    input  logic [NSRC*UW-1:0]           d_use,
    input  logic [REGW-1:0]              d_dst,
    input  logic [SELW-1:0]              d_rdy,
    input  logic                         md_start,
    input  logic                         md_use,
    input  logic                         flush,
    output logic                         stall,
    output logic                         md_busy,
    output logic [NSRC*DEPTH*SELW-1:0]   fwd_sel,
    output logic [REGW-1:0]              w_dst
);

    localparam int CW = $clog2(MDU_LAT + 1);
    localparam int AW = SELW + UW + 1;
    localparam int SW = SELW + 1;

    logic [DEPTH:1]                        r_sb_valid;
    logic [DEPTH:1][REGW-1:0]              r_sb_dst;
    logic [DEPTH:1][SELW-1:0]              r_sb_rdy;
    logic [DEPTH-1:1][NSRC-1:0][SELW-1:0]  r_fk;
    logic [CW-1:0]                         r_cnt;

    logic [NSRC-1:0][SELW-1:0]             w_hit_k;
    logic [NSRC-1:0][SELW-1:0]             w_hit_rdy;
    logic                                  w_data_stall;
    logic                                  w_mdu_stall;
    logic                                  w_stall;

    // Find the youngest matching producer per source and flag results that arrive too late.
    always_comb begin
        w_hit_k      = '0;
        w_hit_rdy    = '0;
        w_data_stall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            // Oldest first so the youngest match overwrites and wins.
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_sb_valid[k] && (d_src[s*REGW +: REGW] != '0) &&
                    (r_sb_dst[k] == d_src[s*REGW +: REGW])) begin
                    w_hit_k[s]   = SELW'(k);
                    w_hit_rdy[s] = r_sb_rdy[k];
                end
            end
            if ((w_hit_k[s] != '0) &&
                (AW'(w_hit_k[s]) + AW'(d_use[s*UW +: UW]) <= AW'(w_hit_rdy[s])))
                w_data_stall = 1'b1;
        end
    end

    assign w_mdu_stall = (md_use | md_start) & (r_cnt != '0);
    // Flush always beats stall: a killed instruction never needs to wait.
    assign w_stall     = d_valid & ~flush & (w_data_stall | w_mdu_stall);
    assign stall       = w_stall;
    assign md_busy     = (r_cnt != '0);
    assign w_dst       = r_sb_valid[DEPTH] ? r_sb_dst[DEPTH] : '0;

    // Stage 0 comes straight from the live hit. Stage j adds j to the captured position.
    // A producer that has already retired past pos DEPTH means the RF value is current.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            for (gj = 0; gj < DEPTH; gj++) begin : g_stage
                if (gj == 0) begin : g_live
                    assign fwd_sel[(gi*DEPTH + gj)*SELW +: SELW] = w_hit_k[gi];
                end else begin : g_pipe
                    logic [SW-1:0] w_sum;
                    assign w_sum = SW'(r_fk[gj][gi]) + SW'(gj);
                    assign fwd_sel[(gi*DEPTH + gj)*SELW +: SELW] =
                        ((r_fk[gj][gi] != '0) && (w_sum <= SW'(DEPTH))) ? w_sum[SELW-1:0] : '0;
                end
            end
        end
    endgenerate

    // Shift the scoreboard. A stalled or flushed D inserts a bubble, and flush also kills pos1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_valid <= '0;
            r_sb_dst   <= '0;
            r_sb_rdy   <= '0;
        end else begin
            r_sb_valid[1] <= d_valid & (d_dst != '0) & ~w_stall & ~flush;
            r_sb_dst[1]   <= d_dst;
            r_sb_rdy[1]   <= d_rdy;
            for (int k = 2; k <= DEPTH; k++) begin
                r_sb_valid[k] <= (k == 2 && flush) ? 1'b0 : r_sb_valid[k-1];
                r_sb_dst[k]   <= r_sb_dst[k-1];
                r_sb_rdy[k]   <= r_sb_rdy[k-1];
            end
        end
    end

    // Carry each source's hit position alongside its instruction. Bubbles carry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fk <= '0;
        end else begin
            r_fk[1] <= (w_stall | flush) ? '0 : w_hit_k;
            for (int j = 2; j < DEPTH; j++)
                r_fk[j] <= (j == 2 && flush) ? '0 : r_fk[j-1];
        end
    end

    // MDU busy counter. It reloads only when the issuing instruction actually leaves D.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (md_start & d_valid & ~w_stall & ~flush)
            r_cnt <= CW'(MDU_LAT);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit.
// The driver issues one D-stage transaction per cycle and pushes the expected outputs.
// Those values come from an in-flight instruction list model. A negedge monitor pops and compares.
module tb_hazard_fwd_unit;

    localparam int NSRC = 3, DEPTH = 3, REGW = 5, MDU_LAT = 5, UW = 2, SELW = 2;
    localparam int FW = NSRC * DEPTH * SELW;

    logic                  clk, rst, d_valid, md_start, md_use, flush;
    logic [NSRC*REGW-1:0]  d_src;
    logic [NSRC*UW-1:0]    d_use;
    logic [REGW-1:0]       d_dst;
    logic [SELW-1:0]       d_rdy;
    logic                  stall, md_busy;
    logic [FW-1:0]         fwd_sel;
    logic [REGW-1:0]       w_dst;

    hazard_fwd_unit #(.NSRC(NSRC), .DEPTH(DEPTH), .REGW(REGW), .MDU_LAT(MDU_LAT),
                      .UW(UW), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_src(d_src), .d_use(d_use),
        .d_dst(d_dst), .d_rdy(d_rdy), .md_start(md_start), .md_use(md_use),
        .flush(flush), .stall(stall), .md_busy(md_busy), .fwd_sel(fwd_sel), .w_dst(w_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            stall;
        logic            md_busy;
        logic [REGW-1:0] w_dst;
        logic [FW-1:0]   fwd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    // Reference model: one record per in-flight instruction at pos 1..DEPTH.
    bit m_valid [1:DEPTH];
    int m_dst   [1:DEPTH];
    int m_rdy   [1:DEPTH];
    int m_k     [1:DEPTH][NSRC];
    int m_cnt;
    int m_hit   [NSRC];
    bit m_stall;
    int cur_src [NSRC];
    int cur_use [NSRC];

    task automatic chk(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", nm, act, req, n_txn);
        end
    endtask

    function automatic exp_t model_eval();
        exp_t e;
        bit   dstall, mstall;
        int   v, kk;
        dstall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            m_hit[s] = 0;
            for (int p = 1; p <= DEPTH; p++)
                if (m_hit[s] == 0 && m_valid[p] && cur_src[s] != 0 && m_dst[p] == cur_src[s])
                    m_hit[s] = p;
            if (m_hit[s] != 0 && m_hit[s] + cur_use[s] <= m_rdy[m_hit[s]])
                dstall = 1'b1;
        end
        mstall  = (md_use || md_start) && (m_cnt != 0);
        m_stall = d_valid && !flush && (dstall || mstall);
        e.stall   = m_stall;
        e.md_busy = (m_cnt != 0);
        e.w_dst   = m_valid[DEPTH] ? REGW'(m_dst[DEPTH]) : '0;
        e.fwd     = '0;
        for (int s = 0; s < NSRC; s++)
            for (int j = 0; j < DEPTH; j++) begin
                kk = (j == 0) ? m_hit[s] : m_k[j][s];
                v  = (kk != 0 && kk + j <= DEPTH) ? kk + j : 0;
                e.fwd[(s*DEPTH + j)*SELW +: SELW] = SELW'(v);
            end
        return e;
    endfunction

    function automatic void model_clear();
        for (int p = 1; p <= DEPTH; p++) begin
            m_valid[p] = 1'b0; m_dst[p] = 0; m_rdy[p] = 0;
            for (int s = 0; s < NSRC; s++) m_k[p][s] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_step();
        bit alive;
        if (rst) begin
            model_clear();
            return;
        end
        for (int p = DEPTH; p >= 2; p--) begin
            m_valid[p] = (p == 2 && flush) ? 1'b0 : m_valid[p-1];
            m_dst[p]   = m_dst[p-1];
            m_rdy[p]   = m_rdy[p-1];
            for (int s = 0; s < NSRC; s++) m_k[p][s] = (p == 2 && flush) ? 0 : m_k[p-1][s];
        end
        alive      = !m_stall && !flush;
        m_valid[1] = alive && d_valid && (d_dst != 0);
        m_dst[1]   = int'(d_dst);
        m_rdy[1]   = int'(d_rdy);
        for (int s = 0; s < NSRC; s++) m_k[1][s] = alive ? m_hit[s] : 0;
        if (md_start && d_valid && alive) m_cnt = MDU_LAT;
        else if (m_cnt > 0)               m_cnt = m_cnt - 1;
    endfunction

    // One D-stage transaction: drive, predict, clock, advance the model.
    task automatic cyc(input bit v, input int s0, input int u0, input int s1, input int u1,
                       input int s2, input int u2, input int dst, input int rdy,
                       input bit ms, input bit mu, input bit fl, input bit r);
        cur_src[0] = s0; cur_src[1] = s1; cur_src[2] = s2;
        cur_use[0] = u0; cur_use[1] = u1; cur_use[2] = u2;
        for (int s = 0; s < NSRC; s++) begin
            d_src[s*REGW +: REGW] = REGW'(cur_src[s]);
            d_use[s*UW +: UW]     = UW'(cur_use[s]);
        end
        d_valid = v; d_dst = REGW'(dst); d_rdy = SELW'(rdy);
        md_start = ms; md_use = mu; flush = fl; rst = r;
        exp_q.push_back(model_eval());
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: stall=%0b md_busy=%0b w_dst=%0d fwd_sel=%h", n_txn, stall,
                     md_busy, w_dst, fwd_sel);
            chk("stall",   longint'(stall),   longint'(e.stall));
            chk("md_busy", longint'(md_busy), longint'(e.md_busy));
            chk("w_dst",   longint'(w_dst),   longint'(e.w_dst));
            chk("fwd_sel", longint'(fwd_sel), longint'(e.fwd));
        end
    end

    initial begin
        rst = 1'b1; d_valid = 0; d_src = '0; d_use = '0; d_dst = '0; d_rdy = 1;
        md_start = 0; md_use = 0; flush = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        // Post-reset state.
        idle(2);
        // ALU producer, consumer in E: forward from pos2.
        cyc(1, 1, 0, 2, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        cyc(1, 3, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        idle(3);
        // Load-use: one stall, then forward from pos3.
        cyc(1, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
        idle(3);
        // Branch consuming an ALU result at D.
        cyc(1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        cyc(1, 5, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 5, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(3);
        // Same register written twice; $0 never tracked.
        cyc(1, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        cyc(1, 6, 1, 0, 0, 6, 2, 11, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 12, 1, 0, 0, 0, 0);
        idle(3);
        // MDU interlock, then a second md_start while busy.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, 0, 0, 13, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(6);
        // Flush of a load-use pair.
        cyc(1, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0);
        cyc(1, 4, 1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0);
        idle(4);
        // Reset mid-MDU.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 0, 1);
        idle(2);
        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) != 0),
                $urandom_range(0, 7), $urandom_range(0, 2),
                $urandom_range(0, 7), $urandom_range(0, 2),
                $urandom_range(0, 7), $urandom_range(0, 2),
                $urandom_range(0, 7), $urandom_range(1, 2),
                ($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end
        idle(1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard detection and operand-forwarding controller for the in-order MIPS pipeline; successor to the fixed 3-source / 5-stage controller.
- Tracks the destination register and result-ready stage of every instruction downstream of decode (D) in a shift-register scoreboard.
- Issues decode stalls, per-source/per-stage forwarding selects, and writeback destination.
- New relative to the previous generation: generic source count and depth, a multi-cycle mult/div (MDU) busy interlock, and a flush input.

Parameters:
NSRC, 3, source operands per instruction
DEPTH, 3, pipeline positions tracked after D (pos1=E, pos2=M, pos3=W)
REGW, 5, register address width
MDU_LAT, 5, MDU busy cycles after issue
UW, $clog2(DEPTH), width of use-stage field
SELW, $clog2(DEPTH+1), width of forwarding select / ready field

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
d_valid  in  1  D holds a real instruction
d_src  in  NSRC*REGW  source register addresses; 0 = no dependency
d_use  in  NSRC*UW  stage index (0..DEPTH-1) at which each source is consumed
d_dst  in  REGW  destination register; 0 = none
d_rdy  in  SELW  stage producing the result (1=E/ALU, 2=M/load)
md_start  in  1  D instruction issues to the MDU
md_use  in  1  D instruction reads HI/LO
flush  in  1  kill the D instruction and the pos1 instruction
stall  out  1  hold PC and the IF/ID register; bubble into E
md_busy  out  1  MDU counter nonzero
fwd_sel  out  NSRC*DEPTH*SELW  select for source s at stage j; 0 = own RF operand, k = result bus at pos k
w_dst  out  REGW  destination of the pos DEPTH instruction (RF write address); 0 if invalid

Behaviour:
- Scoreboard entry per pos k=1..DEPTH holds {valid, dst, rdy}. Each cycle, entries shift k->k+1 and pos DEPTH retires.
- Pos1 loads {d_valid & (d_dst!=0), d_dst, d_rdy}, unless stall or flush is set; then pos1 loads invalid.
- Hit for source s: the smallest k with valid, dst == d_src[s] and d_src[s] != 0. No hit means the source reads the RF.
- Data stall: any hit with k + d_use[s] <= rdy_k.
- MDU stall: (md_use | md_start) & (cnt != 0).
- stall = d_valid & ~flush & (data stall | MDU stall). It is combinational and has no output register.
- MDU counter:
  - Loads MDU_LAT when md_start & d_valid & ~stall & ~flush.
  - Otherwise decrements while nonzero.
  - md_busy = (cnt != 0). Counter is not affected by flush.
- Forwarding pipe: per source, the hit position k (0 = none) is captured at D and carried through stages 1..DEPTH-1 in registers. It is cleared to 0 when the instruction becomes a bubble (stall or flush).
- fwd_sel for (s, j) = k+j if k != 0 and k+j <= DEPTH, else 0. The stage-0 select is combinational from the live hit.
- The select is only meaningful at j == d_use[s]. The consumer ignores other stages.
- Same register hit at several positions: the youngest (smallest k) wins.
- Write to register 0 is never tracked.
- flush and stall together: flush wins, and stall = 0.
- Reset: all entries invalid, forwarding pipe 0, cnt = 0.
  - Next cycle: md_busy = 0, w_dst = 0, fwd_sel stages >= 1 = 0.
  - stall follows the inputs against the empty scoreboard, i.e. 0 unless the MDU is busy, which it cannot be after reset.
  - Reset asserted mid-stall or mid-MDU clears everything in one cycle.

Test Plan:
1. ALU `addu $3` at pos1 (rdy=1), consumer `$3` with d_use=1 -> stall=0; next cycle consumer in E sees fwd_sel(s,1)=2.
2. `lw $4` at pos1 (rdy=2), consumer `$4` with d_use=1 -> stall=1 for exactly one cycle, pos1 becomes a bubble; then stall=0 and fwd_sel(s,1)=3 in E.
3. ALU `$5` at pos1, branch comparing `$5` with d_use=0 -> stall one cycle; next cycle fwd_sel(s,0)=2, stall=0.
4. `$6` written at pos1 and pos2 -> select resolves to pos1; `$0` source with a `$0` producer -> fwd_sel=0, stall=0.
5. md_start issued, then md_use in D on the next cycle -> stall for 5 cycles (md_busy=1 for 5 cycles), released when cnt reaches 0; a second md_start during busy also stalls.
6. `lw` at pos1 with a dependent consumer in D, flush=1 -> stall=0, both killed, w_dst=0 when the bubbles reach pos3; rst mid-MDU -> md_busy=0 the next cycle.
